// File: rtl/cdc_arb_pkg.sv
// cdc_arb_pkg: shared types and helpers for the CDC handshake arbiter.
//   arb_state_e : arbiter FSM states (idle, strobe issue, wait for completion)
//   calc_id_w   : width of a requester index for a given requester count
package cdc_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  // A single requester still needs a one-bit index.
  function automatic int calc_id_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/cdc_handshake_arbiter_picker.sv
// cdc_rr_picker: combinational round-robin selector.
//   pending    in  NUM_REQ  requesters with an outstanding request
//   last_grant in  ID_W     requester served most recently
//   valid      out 1        at least one pending requester
//   index      out ID_W     first pending index after last_grant, wrapping around
module cdc_rr_picker
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = calc_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [ID_W-1:0]    last_grant,
  output logic               valid,
  output logic [ID_W-1:0]    index
);

  logic [ID_W-1:0] cand;

  // Walk from the farthest offset down to the nearest so the nearest pending
  // index after last_grant is the final assignment. Offset NUM_REQ is
  // last_grant itself, which therefore has the lowest priority.
  always_comb begin
    valid = |pending;
    index = last_grant;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (pending[cand]) index = cand;
    end
  end

endmodule

// File: rtl/cdc_handshake_arbiter.sv
// cdc_handshake_arbiter: shares one source-side CDC strobe/stall channel among
// NUM_REQ requesters, round-robin, one transfer in flight. Single clock domain.
//   source_clk, source_reset : clock, synchronous active-high reset
//   req_strobe  in  : one-cycle request pulse per requester
//   req_stall   out : request pending for requester i (further pulses dropped)
//   done_strobe out : one-cycle completion pulse to requester i
//   chan_strobe out : one-cycle strobe into the CDC channel
//   chan_id     out : granted requester index, held through completion
//   chan_stall  in  : channel busy level (synchronized)
//   chan_ack    in  : one-cycle completion pulse from the channel
//   busy        out : FSM not idle
//   timeout_err out : sticky watchdog error
// Optional feature: define CDC_ARB_TIMEOUT_EN to enable the WAIT-state
// watchdog (TIMEOUT_CYCLES). Without it timeout_err is tied low.
module cdc_handshake_arbiter
  import cdc_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int ID_W           = calc_id_w(NUM_REQ)
) (
  input  logic               source_clk,
  input  logic               source_reset,
  input  logic [NUM_REQ-1:0] req_strobe,
  output logic [NUM_REQ-1:0] req_stall,
  output logic [NUM_REQ-1:0] done_strobe,
  output logic               chan_strobe,
  output logic [ID_W-1:0]    chan_id,
  input  logic               chan_stall,
  input  logic               chan_ack,
  output logic               busy,
  output logic               timeout_err
);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("NUM_REQ must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e         state;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] pending_next;
  logic [ID_W-1:0]    grant;
  logic [ID_W-1:0]    last_grant;
  logic               pick_valid;
  logic [ID_W-1:0]    pick_index;
  logic               expire;
  logic               finish;

  cdc_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .pending    (pending),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .index      (pick_index)
  );

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // Fires in the TIMEOUT_CYCLES-th WAIT cycle; a same-cycle ack wins.
  assign expire = (state == ARB_WAIT) && !chan_ack &&
                  (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge source_clk) begin
    if (source_reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ARB_ISSUE)     wait_cnt <= '0;
      else if (state == ARB_WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (expire) err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign finish    = (state == ARB_WAIT) && (chan_ack || expire);
  assign req_stall = pending;
  assign busy      = (state != ARB_IDLE);

  // Pulses arriving while a bit is already set (including the completion
  // cycle, where the clear below wins) are dropped.
  always_comb begin
    pending_next = pending | req_strobe;
    if (finish) pending_next[grant] = 1'b0;
  end

  always_ff @(posedge source_clk) begin
    if (source_reset) begin
      state       <= ARB_IDLE;
      pending     <= '0;
      grant       <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      chan_strobe <= 1'b0;
      chan_id     <= '0;
      done_strobe <= '0;
    end else begin
      pending     <= pending_next;
      chan_strobe <= 1'b0;
      done_strobe <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_valid && !chan_stall) begin
            grant       <= pick_index;
            chan_id     <= pick_index;
            chan_strobe <= 1'b1;
            state       <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: state <= ARB_WAIT;
        ARB_WAIT: begin
          if (finish) begin
            // A watchdog expiry releases the requester without a done pulse.
            if (chan_ack) done_strobe[grant] <= 1'b1;
            last_grant <= grant;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
